// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the sequential multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam logic        OP_MUL = 1'b0;
    localparam logic        OP_DIV = 1'b1;
    localparam int unsigned ITER   = 32;
    localparam int unsigned RES_W  = 64;
    localparam int unsigned CNT_W  = 6;

endpackage

// File: rtl/mdu_div_step.sv
// One non-restoring divide iteration on magnitudes: shift in the next dividend bit,
// add or subtract the divisor by the sign of the partial remainder, emit a quotient bit.
module mdu_div_step
    import mdu_pkg::*;
(
    input  logic [ITER:0]   rem_i,
    input  logic [ITER-1:0] quo_i,
    input  logic [ITER-1:0] dvs_i,
    output logic [ITER:0]   rem_o,
    output logic [ITER-1:0] quo_o
);

    logic [ITER:0] shifted;

    always_comb begin
        // Remainder stays within +/-2^31, so dropping its top bit keeps the value.
        shifted = {rem_i[ITER-1:0], quo_i[ITER-1]};
        if (rem_i[ITER]) begin
            rem_o = shifted + {1'b0, dvs_i};
        end else begin
            rem_o = shifted - {1'b0, dvs_i};
        end
        quo_o = {quo_i[ITER-2:0], ~rem_o[ITER]};
    end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential signed multiply (radix-2 Booth) and optional signed divide, 32 iterations.
// Divide path is compiled in only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [31:0]      Y,
    input  logic [31:0]      B,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] C,
    output logic             div_by_zero
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [64:0]      acc_q, acc_d;
    logic [31:0]      mcand_q, mcand_d;
    logic [RES_W-1:0] c_q, c_d;
    logic [32:0]      booth_sum;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic        div_q, div_d, zero_q, zero_d, qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;
    logic [32:0] rem_q, rem_d, rem_nxt;
    logic [31:0] quo_q, quo_d, quo_nxt, dvs_q, dvs_d, rem_fix;

    mdu_div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nxt),
        .quo_o (quo_nxt)
    );

    // A negative final remainder is restored by one divisor add (result is in [0, divisor)).
    assign rem_fix     = rem_q[31:0] + (rem_q[32] ? dvs_q : 32'd0);
    assign div_by_zero = dbz_q;
`else
    logic unused_op;
    assign unused_op   = op;
    assign div_by_zero = 1'b0;
`endif

    // Booth add is 33 bits wide so a -2^31 multiplicand cannot overflow the upper half.
    always_comb begin
        case (acc_q[1:0])
            2'b01:   booth_sum = {acc_q[64], acc_q[64:33]} + {mcand_q[31], mcand_q};
            2'b10:   booth_sum = {acc_q[64], acc_q[64:33]} - {mcand_q[31], mcand_q};
            default: booth_sum = {acc_q[64], acc_q[64:33]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        c_d     = c_q;
`ifdef MUL_DIV_UNIT_DIV_EN
        div_d   = div_q;
        zero_d  = zero_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    mcand_d = Y;
                    acc_d   = {32'd0, B, 1'b0};
`ifdef MUL_DIV_UNIT_DIV_EN
                    div_d   = (op == OP_DIV);
                    zero_d  = (B == 32'd0);
                    qneg_d  = Y[31] ^ B[31];
                    rneg_d  = Y[31];
                    dbz_d   = 1'b0;
                    rem_d   = '0;
                    quo_d   = Y[31] ? -Y : Y;
                    dvs_d   = B[31] ? -B : B;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(ITER)) begin
                    state_d = DONE;
                    c_d     = acc_q[64:1];
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (div_q) begin
                        c_d = {rneg_q ? -rem_fix : rem_fix, qneg_q ? -quo_q : quo_q};
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = {booth_sum, acc_q[32:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
`endif
                end
`ifdef MUL_DIV_UNIT_DIV_EN
                if (div_q && zero_q) begin
                    state_d = DONE;
                    c_d     = {mcand_q, 32'hFFFF_FFFF};
                    dbz_d   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            c_q     <= c_d;
        end
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            div_q  <= 1'b0;
            zero_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dbz_q  <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            div_q  <= div_d;
            zero_q <= zero_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            dbz_q  <= dbz_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign C    = c_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clock  in  1  sole clock, rising edge
- clear  in  1  synchronous, active-high reset
REQ-002 The block SHALL have these remaining ports:
- start  in  1  operation request, sampled on the rising clock edge
- op  in  1  0 = signed multiply, 1 = signed divide
- Y  in  32  operand A (multiplicand or dividend), driven from the Y register
- B  in  32  operand B (multiplier or divisor), driven from BusMuxOut
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- C  out  64  result, feeding the Zhigh/Zlow register inputs
- div_by_zero  out  1  sticky flag for the last divide; high when the divisor was 0

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-004 When start=1 in IDLE or DONE, the block SHALL capture Y, B and op, clear the iteration counter and enter RUN on the same edge.
REQ-005 start SHALL be ignored while in RUN.
REQ-006 RUN SHALL perform exactly 32 iterations, one per clock, then enter DONE.
REQ-007 done SHALL be high for exactly one cycle, 33 cycles after the start-sampling edge; it SHALL then fall to 0.
REQ-008 busy SHALL be 1 exactly while in RUN.
REQ-009 DONE SHALL return to IDLE on the next edge unless start=1.
REQ-010 Multiply SHALL be radix-2 Booth, two's-complement, with a full 64-bit product on C.
REQ-011 Divide SHALL be signed non-restoring division with these result rules:
- C[31:0] = quotient, truncated toward zero
- C[63:32] = remainder, carrying the sign of the dividend
REQ-012 For 0x80000000 / 0xFFFFFFFF, C SHALL be {32'h0, 32'h80000000}, and no flag SHALL be raised.
REQ-013 A divide with B=0 SHALL skip RUN and enter DONE on the next edge, with:
- C = {Y, 32'hFFFFFFFF}
- div_by_zero = 1
REQ-014 div_by_zero SHALL clear on the next accepted start.
REQ-015 C SHALL hold the last result from DONE until the next accepted start.
REQ-016 C SHALL be undefined-free while in RUN: it SHALL hold the previous result, not intermediate values.
REQ-017 Internal accumulators SHALL be 65 bits for multiply (product plus Booth guard bit) and 33 bits for the divide partial remainder; no other width truncation is permitted.

Reset
REQ-018 clear=1 at a rising edge SHALL force IDLE, busy=0, done=0, C=0, div_by_zero=0 and counter=0, regardless of state, including mid-RUN.
REQ-019 If clear and start are both 1 on the same edge, clear SHALL win and start SHALL be discarded.

Configuration
REQ-020 The feature macro SHALL be named MUL_DIV_UNIT_DIV_EN.
REQ-021 When MUL_DIV_UNIT_DIV_EN is defined, the divide path SHALL be compiled in as specified above.
REQ-022 When MUL_DIV_UNIT_DIV_EN is undefined, the divide path SHALL be compiled out, with this behaviour:
- op SHALL be ignored and every operation SHALL be a multiply
- div_by_zero SHALL be tied to 0
- no divide logic SHALL be synthesised

Structure
REQ-023 The shared package mdu_pkg SHALL hold the following:
- state encodings: IDLE, RUN, DONE
- op encodings: OP_MUL = 0, OP_DIV = 1
- ITER = 32
- the result width constant, 64
REQ-024 The divide iteration SHALL live in one sub-module, mdu_div_step, instantiated only under MUL_DIV_UNIT_DIV_EN.
- Inputs: partial remainder, quotient, divisor.
- Outputs: next partial remainder, next quotient.
REQ-025 Booth multiply and the FSM SHALL reside in mul_div_unit itself.

Verification
REQ-026 Multiply negative: op=0, Y=6, B=0xFFFFFFF9 (-7) -> done after 33 cycles, C=0xFFFFFFFF_FFFFFFD6.
REQ-027 Multiply extreme: op=0, Y=B=0x80000000 -> C=0x40000000_00000000.
REQ-028 Divide signs: two cases are required.
- Y=17, B=0xFFFFFFFB (-5) -> C[31:0]=0xFFFFFFFD, C[63:32]=2.
- Y=0xFFFFFFEF (-17), B=5 -> C[31:0]=0xFFFFFFFD, C[63:32]=0xFFFFFFFE.
REQ-029 Divide by zero: op=1, Y=0x1234, B=0 -> done on the second edge after start, C=0x00001234_FFFFFFFF, div_by_zero=1; a following multiply start clears the flag.
REQ-030 Busy and reset behaviour: two cases are required.
- A second start at cycle 10 of RUN is ignored, with a single done at cycle 33 and the original operands' result.
- clear at cycle 20 of RUN returns all outputs to 0 and produces no done.
REQ-031 The bench SHALL be built with MUL_DIV_UNIT_DIV_EN undefined and rerun REQ-026 and REQ-027 with op=1 -> the product result is returned and div_by_zero=0.
